requant_narrow_20b: RTL

- Narrows signed 20-bit adder results back to signed 8-bit activations for the next NPU layer; this is the reverse of the 19→20-bit widening adder path.
- Each result gets a configurable rounding arithmetic right shift, optional ReLU and saturation to the output width.
- Two-stage elastic pipeline with valid/ready on both sides, plus a saturation event counter for quantisation tuning.

---
 rtl/requant_narrow_20b.sv | 136 +++++++++++++
 1 files changed

// File: rtl/requant_narrow_20b.sv
// Narrows signed IN_W-bit adder sums to signed OUT_W-bit activations through a
// two-stage valid/ready pipeline: rounding shift, then ReLU/saturation, with a sticky saturation counter.
module requant_narrow_20b #(
  parameter int unsigned IN_W    = 20,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned SHIFT_W = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [IN_W-1:0]    in_data_i,
  input  logic               in_ovf_i,
  input  logic [SHIFT_W-1:0] shift_i,
  input  logic               relu_en_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [OUT_W-1:0]   out_data_o,
  output logic               out_sat_o,
  input  logic               clr_count_i,
  output logic [CNT_W-1:0]   sat_count_o
);

  localparam int unsigned RW = IN_W + 1;
  localparam logic signed [RW-1:0] MAXV = RW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [RW-1:0] MINV = ~MAXV;
  localparam logic [OUT_W-1:0] OMAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OMIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic                 r_run;
  logic                 r_s1_valid;
  logic signed [RW-1:0] r_s1_r;
  logic                 r_s1_ovf;
  logic                 r_s1_relu;
  logic                 r_s1_xmsb;
  logic                 r_s2_valid;
  logic [OUT_W-1:0]     r_out_data;
  logic                 r_out_sat;
  logic [CNT_W-1:0]     r_cnt;

  logic                 w_s1_adv;
  logic                 w_in_xfer;
  logic                 w_s2_load;
  logic                 w_out_xfer;
  logic signed [RW-1:0] w_x;
  logic signed [RW-1:0] w_rnd;
  logic signed [RW-1:0] w_sum;
  logic signed [RW-1:0] w_r;
  logic [OUT_W-1:0]     w_q;
  logic                 w_qsat;

  assign w_s1_adv   = !r_s2_valid || out_ready_i;
  assign in_ready_o = r_run && (!r_s1_valid || w_s1_adv);
  assign w_in_xfer  = in_valid_i && in_ready_o;
  assign w_s2_load  = r_s1_valid && w_s1_adv;
  assign w_out_xfer = r_s2_valid && out_ready_i;

  // Half-LSB rounding term; shifting a one left then right yields 0 for shift 0.
  assign w_x   = {in_data_i[IN_W-1], in_data_i};
  assign w_rnd = (RW'(1) << shift_i) >> 1;
  assign w_sum = w_x + w_rnd;
  assign w_r   = w_sum >>> shift_i;

  // Upstream overflow means the true sign is the inverse of the stored MSB.
  always_comb begin
    w_q    = '0;
    w_qsat = 1'b0;
    if (r_s1_ovf) begin
      w_qsat = 1'b1;
      if (r_s1_xmsb)      w_q = OMAX;
      else if (r_s1_relu) w_q = '0;
      else                w_q = OMIN;
    end else if (r_s1_relu && r_s1_r[RW-1]) begin
      w_q = '0;
    end else if (r_s1_r > MAXV) begin
      w_q    = OMAX;
      w_qsat = 1'b1;
    end else if (r_s1_r < MINV) begin
      w_q    = OMIN;
      w_qsat = 1'b1;
    end else begin
      w_q = r_s1_r[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_run      <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_r     <= '0;
      r_s1_ovf   <= 1'b0;
      r_s1_relu  <= 1'b0;
      r_s1_xmsb  <= 1'b0;
    end else begin
      r_run      <= 1'b1;
      r_s1_valid <= w_in_xfer || (r_s1_valid && !w_s1_adv);
      if (w_in_xfer) begin
        r_s1_r    <= w_r;
        r_s1_ovf  <= in_ovf_i;
        r_s1_relu <= relu_en_i;
        r_s1_xmsb <= in_data_i[IN_W-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s2_valid <= 1'b0;
      r_out_data <= '0;
      r_out_sat  <= 1'b0;
    end else begin
      if (w_s1_adv) r_s2_valid <= r_s1_valid;
      if (w_s2_load) begin
        r_out_data <= w_q;
        r_out_sat  <= w_qsat;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (clr_count_i) begin
      r_cnt <= '0;
    end else if (w_out_xfer && r_out_sat && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out_valid_o = r_s2_valid;
  assign out_data_o  = r_out_data;
  assign out_sat_o   = r_out_sat;
  assign sat_count_o = r_cnt;

endmodule
